// File: rtl/data_island_scheduler.sv
// HDMI data island slot scheduler: grants ACR, audio sample, InfoFrame or null packets per framer slot.
// Optional audio InfoFrame scheduling is enabled by defining DATA_ISLAND_AUDIO_INFOFRAME_EN.
module data_island_scheduler #(
  parameter int unsigned ACR_INTERVAL_CYCLES = 27000,
  parameter int unsigned PACKET_CYCLES       = 32
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       slot_request,
  input  logic       sample_ready,
  output logic       sample_ack,
  output logic       packet_valid,
  output logic [7:0] packet_type,
  output logic       slot_overrun
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  localparam logic [7:0]  TYPE_NULL  = 8'h00;
  localparam logic [7:0]  TYPE_ACR   = 8'h01;
  localparam logic [7:0]  TYPE_AUDIO = 8'h02;
  localparam logic [7:0]  TYPE_AIF   = 8'h84;
  localparam logic [19:0] ACR_LAST   = 20'(ACR_INTERVAL_CYCLES - 1);
  localparam logic [7:0]  BUSY_LAST  = 8'(PACKET_CYCLES - 3);
  localparam logic        NO_BUSY    = (PACKET_CYCLES == 2);

  state_t      state_q, state_d;
  logic [7:0]  busy_cnt_q, busy_cnt_d;
  logic [7:0]  type_q, type_d;
  logic        overrun_q, overrun_d;
  logic [19:0] acr_cnt_q, acr_cnt_d;
  logic        acr_pending_q, acr_pending_d;
  logic        aif_pending;
  logic        acr_wrap;
  logic        in_grant;
  logic [7:0]  grant_type;

  assign in_grant = (state_q == GRANT);
  assign acr_wrap = (acr_cnt_q == ACR_LAST);

`ifdef DATA_ISLAND_AUDIO_INFOFRAME_EN
  logic aif_pending_q, aif_pending_d;

  // A frame_start coincident with the InfoFrame grant re-arms the request.
  always_comb begin
    aif_pending_d = aif_pending_q;
    if (frame_start)
      aif_pending_d = 1'b1;
    else if (in_grant && type_q == TYPE_AIF)
      aif_pending_d = 1'b0;
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) aif_pending_q <= 1'b1;
    else          aif_pending_q <= aif_pending_d;
  end

  assign aif_pending = aif_pending_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign aif_pending        = 1'b0;
`endif

  always_comb begin
    grant_type = TYPE_NULL;
    if (acr_pending_q)     grant_type = TYPE_ACR;
    else if (sample_ready) grant_type = TYPE_AUDIO;
    else if (aif_pending)  grant_type = TYPE_AIF;
  end

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    type_d     = type_q;
    case (state_q)
      IDLE: begin
        if (slot_request) begin
          state_d = GRANT;
          type_d  = grant_type;
        end
      end
      GRANT: begin
        busy_cnt_d = '0;
        state_d    = NO_BUSY ? IDLE : BUSY;
      end
      BUSY: begin
        if (busy_cnt_q == BUSY_LAST) state_d = IDLE;
        else                         busy_cnt_d = busy_cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q | (slot_request && state_q != IDLE);
    acr_cnt_d = acr_wrap ? '0 : acr_cnt_q + 20'd1;
    // A wrap in the same cycle as the ACR grant keeps the request pending.
    acr_pending_d = acr_pending_q;
    if (acr_wrap)
      acr_pending_d = 1'b1;
    else if (in_grant && type_q == TYPE_ACR)
      acr_pending_d = 1'b0;
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      busy_cnt_q    <= '0;
      type_q        <= TYPE_NULL;
      overrun_q     <= 1'b0;
      acr_cnt_q     <= '0;
      acr_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_cnt_q    <= busy_cnt_d;
      type_q        <= type_d;
      overrun_q     <= overrun_d;
      acr_cnt_q     <= acr_cnt_d;
      acr_pending_q <= acr_pending_d;
    end
  end

  assign packet_valid = in_grant;
  assign sample_ack   = in_grant && (type_q == TYPE_AUDIO);
  assign packet_type  = type_q;
  assign slot_overrun = overrun_q;

endmodule

// File: doc/data_island_scheduler.md
DATA_ISLAND_SCHEDULER -- requirements
Module: data_island_scheduler

Interface
REQ-001 SHALL have parameter ACR_INTERVAL_CYCLES, default 27000, meaning clk_pixel cycles between Audio Clock Regeneration requests; legal range 2..1048575.
REQ-002 SHALL have parameter PACKET_CYCLES, default 32, meaning clk_pixel cycles one data island packet occupies; legal range 2..255.
REQ-003 SHALL have port clk_pixel  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse at start of each video frame.
REQ-006 SHALL have port slot_request  input  1  one-cycle pulse: framer can accept a packet now.
REQ-007 SHALL have port sample_ready  input  1  audio buffer holds at least one stereo sample pair.
REQ-008 SHALL have port sample_ack  output  1  one-cycle pop of one stereo pair from the audio buffer.
REQ-009 SHALL have port packet_valid  output  1  one-cycle strobe: packet_type is a grant.
REQ-010 SHALL have port packet_type  output  8  HB0 of granted packet: 0x00 null, 0x01 ACR, 0x02 audio sample, 0x84 audio InfoFrame.
REQ-011 SHALL have port slot_overrun  output  1  sticky flag: slot_request arrived while a packet was in progress.

Function
REQ-012 SHALL implement states IDLE, GRANT, BUSY.
REQ-013 IDLE + slot_request: go to GRANT next cycle; packet type chosen from pending state sampled in the slot_request cycle.
REQ-014 GRANT lasts exactly one cycle; packet_valid=1, packet_type held; then BUSY.
REQ-015 BUSY lasts PACKET_CYCLES-2 cycles, then IDLE; total GRANT+BUSY = PACKET_CYCLES-1 cycles, so a back-to-back slot_request every PACKET_CYCLES cycles is always accepted.
REQ-016 Priority at decision: acr_pending > sample_ready > infoframe_pending > null.
REQ-017 packet_type SHALL hold its last granted value outside GRANT.
REQ-018 sample_ack SHALL pulse in the GRANT cycle only when the grant is type 0x02; never otherwise.
REQ-019 ACR counter SHALL be 20 bits and count 0..ACR_INTERVAL_CYCLES-1 free-running, then wrap to 0; acr_pending is set in the cycle after the wrap.
REQ-020 acr_pending SHALL clear on ACR grant; a wrap in the same cycle as the grant SHALL leave it set (set wins).
REQ-021 infoframe_pending SHALL set the cycle after frame_start and clear on InfoFrame grant; a frame_start coincident with the grant wins (stays set). Multiple frame_starts while pending SHALL queue only one InfoFrame.
REQ-022 slot_request in GRANT or BUSY SHALL be ignored (no grant, no state change) and SHALL set slot_overrun.
REQ-023 frame_start and ACR wrap SHALL be honoured in every state, including GRANT/BUSY.
REQ-024 A null grant (0x00) SHALL still run the full GRANT/BUSY sequence.

Reset
REQ-025 On reset_n low: state IDLE, packet_valid 0, packet_type 0x00, sample_ack 0, slot_overrun 0, ACR counter 0, acr_pending 0, infoframe_pending 1 (0 when macro absent).
REQ-026 Reset mid-packet SHALL abort immediately; no sample_ack is issued after reset asserts.
REQ-027 slot_overrun SHALL clear only on reset.

Configuration
REQ-028 Macro DATA_ISLAND_AUDIO_INFOFRAME_EN defined: InfoFrame scheduling per REQ-021, REQ-025.
REQ-029 Macro undefined: infoframe_pending logic absent, frame_start ignored, type 0x84 never granted; all else unchanged.

Verification
REQ-030 Reset release, macro on, sample_ready=0, slot_request at cycle 5 -> packet_valid at cycle 6, packet_type 0x84, sample_ack 0.
REQ-031 sample_ready=1 held, slot_request every 32 cycles ×4 -> four grants of 0x02, four sample_ack pulses, slot_overrun stays 0.
REQ-032 ACR_INTERVAL_CYCLES=100, sample_ready=1, slot every 32 cycles -> one 0x01 at the first slot after each wrap, else 0x02; ACR grants spaced ~100 cycles.
REQ-033 slot_request 10 cycles after a grant -> no packet_valid for it, slot_overrun=1 until reset.
REQ-034 frame_start in the same cycle as an InfoFrame GRANT -> next idle slot grants 0x84 again; with macro off -> only 0x00/0x01/0x02 ever seen.
REQ-035 reset_n low in the 3rd BUSY cycle -> outputs at reset values same cycle; next slot_request after release gives a normal grant one cycle later.
